// File: rtl/parcel_fetch_queue.sv
// parcel_fetch_queue
// Circular queue of 16-bit instruction parcels between the fetch memory port
// and the PD stage. Fetch words of FETCH_PARCELS parcels go in; one aligned
// instruction (16-bit compressed or 32-bit) comes out per cycle. A 32-bit
// instruction split across two fetch words is assembled naturally because the
// lower parcel simply waits in the queue until the upper one arrives.
//
// Ports:
//   i_clk            clock
//   i_rst_n          asynchronous active-low reset
//   i_fetch_valid    fetch word available
//   o_fetch_ready    queue has room for a whole fetch word
//   i_fetch_data     fetch word, parcel k = bits [16k+15:16k]
//   i_flush          redirect, discards queue contents
//   i_flush_pc       redirect target (2-byte aligned)
//   o_instr_valid    aligned instruction available
//   i_instr_ready    PD stage consumes instruction
//   o_instr          instruction, compressed ones zero-extended
//   o_instr_pc       PC of o_instr
//   o_is_compressed  head parcel bits [1:0] != 2'b11
//   o_count          parcel occupancy
module parcel_fetch_queue #(
   parameter int unsigned     XLEN          = 32,
   parameter int unsigned     FETCH_PARCELS = 2,
   parameter int unsigned     DEPTH         = 8,
   parameter logic [XLEN-1:0] RESET_PC      = '0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_fetch_valid,
   output logic                      o_fetch_ready,
   input  logic [16*FETCH_PARCELS-1:0] i_fetch_data,
   input  logic                      i_flush,
   input  logic [XLEN-1:0]           i_flush_pc,
   output logic                      o_instr_valid,
   input  logic                      i_instr_ready,
   output logic [31:0]               o_instr,
   output logic [XLEN-1:0]           o_instr_pc,
   output logic                      o_is_compressed,
   output logic [$clog2(DEPTH):0]    o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SKP_W = $clog2(FETCH_PARCELS);

   logic [15:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [XLEN-1:0]  r_head_pc;
   logic             r_skip_pending;
   logic [SKP_W-1:0] r_skip_n;

   logic [15:0]      w_head;
   logic [15:0]      w_next;
   logic             w_comp;
   logic             w_instr_valid;
   logic             w_fetch_ready;
   logic             w_enq;
   logic             w_deq;
   logic [SKP_W-1:0] w_skip;
   logic [CNT_W-1:0] w_n_enq;
   logic [CNT_W-1:0] w_n_deq;

   assign w_head = r_mem[r_rd_ptr];
   assign w_next = r_mem[r_rd_ptr + PTR_W'(1)];
   assign w_comp = (w_head[1:0] != 2'b11);

   // A 32-bit head waits for its upper parcel; nothing is emitted meanwhile.
   assign w_instr_valid = ((r_count >= CNT_W'(1)) && w_comp) || (r_count >= CNT_W'(2));

   // Room check uses registered occupancy only, so it never depends on a
   // same-cycle dequeue or flush.
   assign w_fetch_ready = (r_count <= CNT_W'(DEPTH - FETCH_PARCELS));

   assign w_enq = i_fetch_valid && w_fetch_ready && !i_flush;
   assign w_deq = w_instr_valid && i_instr_ready && !i_flush;

   // Parcels below the redirect target in the first word after a flush are dropped.
   assign w_skip  = r_skip_pending ? r_skip_n : '0;
   assign w_n_enq = CNT_W'(FETCH_PARCELS) - CNT_W'(w_skip);
   assign w_n_deq = w_comp ? CNT_W'(1) : CNT_W'(2);

   // Parcel storage, deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (w_enq) begin
         for (int k = 0; k < FETCH_PARCELS; k++) begin
            if (SKP_W'(k) >= w_skip) begin
               r_mem[r_wr_ptr + PTR_W'(k) - PTR_W'(w_skip)] <= i_fetch_data[16*k +: 16];
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr       <= '0;
         r_wr_ptr       <= '0;
         r_count        <= '0;
         r_head_pc      <= RESET_PC;
         r_skip_pending <= 1'b1;
         r_skip_n       <= RESET_PC[SKP_W:1];
      end else if (i_flush) begin
         r_count        <= '0;
         r_rd_ptr       <= r_wr_ptr;
         r_head_pc      <= i_flush_pc;
         r_skip_pending <= 1'b1;
         r_skip_n       <= i_flush_pc[SKP_W:1];
      end else begin
         if (w_enq) begin
            r_wr_ptr       <= r_wr_ptr + PTR_W'(w_n_enq);
            r_skip_pending <= 1'b0;
         end
         if (w_deq) begin
            r_rd_ptr  <= r_rd_ptr + PTR_W'(w_n_deq);
            r_head_pc <= r_head_pc + XLEN'({w_n_deq, 1'b0});
         end
         r_count <= r_count + (w_enq ? w_n_enq : '0) - (w_deq ? w_n_deq : '0);
      end
   end

   assign o_fetch_ready   = w_fetch_ready;
   assign o_instr_valid   = w_instr_valid;
   assign o_is_compressed = w_comp;
   assign o_instr         = w_comp ? {16'h0000, w_head} : {w_next, w_head};
   assign o_instr_pc      = r_head_pc;
   assign o_count         = r_count;

   a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      r_count <= CNT_W'(DEPTH));
   a_pc_aligned: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      r_head_pc[0] == 1'b0);
   a_fetch_known: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_fetch_valid |-> !$isunknown(i_fetch_data));

endmodule

// File: tb/tb_parcel_fetch_queue.sv
module tb_parcel_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   // Main instance: 32-bit fetch, 8-parcel queue.
   logic        fv = 1'b0;
   logic [31:0] fdata = '0;
   logic        fl = 1'b0;
   logic [31:0] fpc = '0;
   logic        rdy = 1'b0;
   logic        f_ready, i_valid, i_comp;
   logic [31:0] instr, ipc;
   logic [3:0]  cnt;

   // Second instance: 64-bit fetch, 16-parcel queue.
   logic        b_fv = 1'b0;
   logic [63:0] b_fdata = '0;
   logic        b_fl = 1'b0;
   logic [31:0] b_fpc = '0;
   logic        b_rdy = 1'b0;
   logic        b_f_ready, b_i_valid, b_i_comp;
   logic [31:0] b_instr, b_ipc;
   logic [4:0]  b_cnt;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the main instance.
   logic [15:0] mq[$];
   logic [31:0] m_pc;
   bit          m_skip;
   int          m_skip_n;

   always #5 clk = ~clk;

   parcel_fetch_queue #(.XLEN(32), .FETCH_PARCELS(2), .DEPTH(8), .RESET_PC(32'h0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_fetch_valid(fv), .o_fetch_ready(f_ready),
      .i_fetch_data(fdata), .i_flush(fl), .i_flush_pc(fpc), .o_instr_valid(i_valid),
      .i_instr_ready(rdy), .o_instr(instr), .o_instr_pc(ipc), .o_is_compressed(i_comp),
      .o_count(cnt)
   );

   parcel_fetch_queue #(.XLEN(32), .FETCH_PARCELS(4), .DEPTH(16), .RESET_PC(32'h0)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_fetch_valid(b_fv), .o_fetch_ready(b_f_ready),
      .i_fetch_data(b_fdata), .i_flush(b_fl), .i_flush_pc(b_fpc), .o_instr_valid(b_i_valid),
      .i_instr_ready(b_rdy), .o_instr(b_instr), .o_instr_pc(b_ipc), .o_is_compressed(b_i_comp),
      .o_count(b_cnt)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic f,
                        input logic [31:0] p, input logic r);
      fv = v; fdata = d; fl = f; fpc = p; rdy = r;
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc = 32'h0;
      m_skip = 1'b1;
      m_skip_n = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      b_fv = 1'b0; b_fl = 1'b0; b_rdy = 1'b0;
      #1;
      chk("async_reset_count", 64'(cnt), 64'd0);
      chk("async_reset_valid", 64'(i_valid), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   function automatic logic [15:0] par(input int i);
      return 16'(32'h1000 | (i << 2) | 1);
   endfunction

   // Compare DUT outputs with the model, then pick random inputs and advance the model.
   task automatic rand_cycle();
      int sz;
      logic [15:0] h;
      bit e_comp, e_valid, e_ready;
      logic [31:0] e_instr;
      logic [15:0] p;
      sz = mq.size();
      e_ready = (8 - sz) >= 2;
      e_comp = 1'b0;
      e_valid = 1'b0;
      e_instr = '0;
      if (sz >= 1) begin
         h = mq[0];
         e_comp = (h[1:0] != 2'b11);
         e_valid = e_comp || sz >= 2;
         e_instr = e_comp ? {16'h0, h} : ((sz >= 2) ? {mq[1], h} : 32'h0);
      end
      chk("rnd_count", 64'(cnt), 64'(sz));
      chk("rnd_fetch_ready", 64'(f_ready), 64'(e_ready));
      chk("rnd_valid", 64'(i_valid), 64'(e_valid));
      chk("rnd_pc", 64'(ipc), 64'(m_pc));
      if (sz >= 1) chk("rnd_comp", 64'(i_comp), 64'(e_comp));
      if (e_valid) chk("rnd_instr", 64'(instr), 64'(e_instr));

      fv = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
         p = 16'($urandom);
         if ($urandom_range(0, 1) == 1) p[1:0] = 2'b11;
         else if (p[1:0] == 2'b11) p[0] = 1'b0;
         fdata[16*k +: 16] = p;
      end
      fl = ($urandom_range(0, 39) == 0);
      fpc = $urandom & 32'h0000_FFFE;
      rdy = ($urandom_range(0, 3) != 0);

      if (fl) begin
         mq.delete();
         m_pc = fpc;
         m_skip = 1'b1;
         m_skip_n = int'(fpc[1]);
      end else begin
         if (e_valid && rdy) begin
            void'(mq.pop_front());
            if (!e_comp) void'(mq.pop_front());
            m_pc = m_pc + (e_comp ? 32'd2 : 32'd4);
         end
         if (fv && e_ready) begin
            for (int k = (m_skip ? m_skip_n : 0); k < 2; k++) mq.push_back(fdata[16*k +: 16]);
            m_skip = 1'b0;
         end
      end
      tick();
   endtask

   initial begin
      int k;
      int sent;
      model_reset();
      do_reset();

      // Reset state.
      chk("reset_valid", 64'(i_valid), 64'd0);
      chk("reset_fetch_ready", 64'(f_ready), 64'd1);
      chk("reset_count", 64'(cnt), 64'd0);
      chk("reset_pc", 64'(ipc), 64'd0);

      // Straight-line sequence: 32-bit then two compressed.
      drive(1'b1, 32'h00A00513, 1'b0, 32'h0, 1'b1);
      tick();
      chk("seq_instr0", 64'(instr), 64'h00A00513);
      chk("seq_pc0", 64'(ipc), 64'h0);
      chk("seq_comp0", 64'(i_comp), 64'd0);
      drive(1'b1, 32'h45854501, 1'b0, 32'h0, 1'b1);
      tick();
      chk("seq_instr1", 64'(instr), 64'h00004501);
      chk("seq_pc1", 64'(ipc), 64'h4);
      chk("seq_comp1", 64'(i_comp), 64'd1);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      tick();
      chk("seq_instr2", 64'(instr), 64'h00004585);
      chk("seq_pc2", 64'(ipc), 64'h6);
      chk("seq_comp2", 64'(i_comp), 64'd1);
      tick();
      chk("seq_empty", 64'(i_valid), 64'd0);

      // Spanning 32-bit instruction with a held second word.
      do_reset();
      drive(1'b1, 32'h05134501, 1'b0, 32'h0, 1'b1);
      tick();
      chk("span_instr0", 64'(instr), 64'h00004501);
      chk("span_pc0", 64'(ipc), 64'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("span_hold_valid", 64'(i_valid), 64'd0);
         chk("span_hold_count", 64'(cnt), 64'd1);
      end
      drive(1'b1, 32'h000000A0, 1'b0, 32'h0, 1'b1);
      tick();
      chk("span_valid", 64'(i_valid), 64'd1);
      chk("span_instr1", 64'(instr), 64'h00A00513);
      chk("span_pc1", 64'(ipc), 64'h2);

      // Flush to a halfword target, on both instances.
      drive(1'b0, 32'h0, 1'b1, 32'h102, 1'b0);
      b_fl = 1'b1; b_fpc = 32'h106;
      tick();
      chk("flush_count", 64'(cnt), 64'd0);
      chk("flush_pc", 64'(ipc), 64'h102);
      chk("flush_valid", 64'(i_valid), 64'd0);
      drive(1'b1, 32'h45854501, 1'b0, 32'h0, 1'b0);
      b_fl = 1'b0; b_fv = 1'b1; b_fdata = 64'h4585_0513_00A0_4501;
      tick();
      b_fv = 1'b0;
      chk("flush_skip_count", 64'(cnt), 64'd1);
      chk("flush_skip_instr", 64'(instr), 64'h00004585);
      chk("flush_skip_ipc", 64'(ipc), 64'h102);
      chk("flush_skip_valid", 64'(i_valid), 64'd1);
      chk("fp4_count", 64'(b_cnt), 64'd1);
      chk("fp4_instr", 64'(b_instr), 64'h00004585);
      chk("fp4_pc", 64'(b_ipc), 64'h106);
      chk("fp4_valid", 64'(b_i_valid), 64'd1);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      tick();
      chk("flush_drain_count", 64'(cnt), 64'd0);
      chk("flush_drain_pc", 64'(ipc), 64'h104);

      // Fill to capacity, then stream across the pointer wrap.
      do_reset();
      for (int w = 0; w < 4; w++) begin
         drive(1'b1, {par(2*w+1), par(2*w)}, 1'b0, 32'h0, 1'b0);
         tick();
      end
      chk("full_count", 64'(cnt), 64'd8);
      chk("full_fetch_ready", 64'(f_ready), 64'd0);
      k = 0;
      sent = 4;
      for (int c = 0; c < 200 && k < 32; c++) begin
         chk("wrap_valid", 64'(i_valid), 64'd1);
         if (i_valid) begin
            chk("wrap_instr", 64'(instr), 64'({16'h0, par(k)}));
            chk("wrap_pc", 64'(ipc), 64'(2*k));
            k++;
         end
         drive(sent < 16, {par(2*sent+1), par(2*sent)}, 1'b0, 32'h0, 1'b1);
         if (sent < 16 && f_ready) sent++;
         tick();
      end
      chk("wrap_total", 64'(k), 64'd32);
      chk("wrap_end_count", 64'(cnt), 64'd0);

      // Flush coinciding with a fetch accept and an instruction handshake.
      do_reset();
      drive(1'b1, 32'h45854501, 1'b0, 32'h0, 1'b0);
      tick();
      chk("coll_pre_count", 64'(cnt), 64'd2);
      drive(1'b1, 32'h12345678, 1'b1, 32'h40, 1'b1);
      tick();
      chk("coll_count", 64'(cnt), 64'd0);
      chk("coll_pc", 64'(ipc), 64'h40);
      chk("coll_valid", 64'(i_valid), 64'd0);
      chk("coll_fetch_ready", 64'(f_ready), 64'd1);
      drive(1'b1, 32'h00010005, 1'b0, 32'h0, 1'b0);
      tick();
      chk("coll_post_count", 64'(cnt), 64'd2);
      chk("coll_post_instr", 64'(instr), 64'h00000005);
      chk("coll_post_pc", 64'(ipc), 64'h40);

      // Randomized run against the model, with one reset in the middle.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         rand_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/parcel_fetch_queue.md
Name: parcel_fetch_queue

Overview:
- Parametrised circular queue of 16-bit instruction parcels between the fetch memory port and the PD stage.
- Accepts fetch words of FETCH_PARCELS parcels and emits one aligned instruction per cycle, either 16-bit compressed or 32-bit.
- Stores state across cycles, so 32-bit instructions that span fetch words are handled without special spanning or holdoff signals.
- Supports wider fetch words (64/128-bit) and redirects to halfword targets.

Parameters:
- XLEN, 32, width of PC.
- FETCH_PARCELS, 2, parcels per fetch word. Power of 2, >=2 (2 = 32-bit fetch, 4 = 64-bit fetch).
- DEPTH, 8, queue capacity in parcels. Power of 2, >= 2*FETCH_PARCELS.
- RESET_PC, 32'h0, head PC after reset. Must be 2-byte aligned.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_fetch_valid  in  1  fetch word available
- o_fetch_ready  out  1  queue can accept a whole fetch word
- i_fetch_data  in  16*FETCH_PARCELS  fetch word; parcel k = bits [16k+15:16k]
- i_flush  in  1  redirect: discard queue contents
- i_flush_pc  in  XLEN  redirect target, 2-byte aligned
- o_instr_valid  out  1  aligned instruction available
- i_instr_ready  in  1  PD stage consumes instruction
- o_instr  out  32  instruction. Compressed: {16'h0, parcel}
- o_instr_pc  out  XLEN  PC of o_instr
- o_is_compressed  out  1  head parcel bits [1:0] != 2'b11
- o_count  out  $clog2(DEPTH)+1  parcel occupancy

Behaviour:
State:
- Storage: DEPTH x 16 array (not reset).
- rd_ptr, wr_ptr: $clog2(DEPTH) bits, wrap modulo DEPTH.
- count register.
- head_pc register.
- skip_pending flag, plus skip_n register of $clog2(FETCH_PARCELS) bits.

Reset (async):
- count=0, rd_ptr=wr_ptr=0, head_pc=RESET_PC.
- skip_pending=1, skip_n=RESET_PC[$clog2(FETCH_PARCELS):1].
- Resulting outputs: o_instr_valid=0, o_fetch_ready=1, o_count=0.

Enqueue:
- o_fetch_ready = (DEPTH - count) >= FETCH_PARCELS. Driven from registered count only; it does not depend on a same-cycle dequeue or on i_flush.
- Accept occurs when i_fetch_valid && o_fetch_ready && !i_flush.
- If skip_pending: parcels skip_n..FETCH_PARCELS-1 are written, in order, starting at wr_ptr. n_enq = FETCH_PARCELS - skip_n. skip_pending is then cleared.
- Otherwise all parcels are written and n_enq = FETCH_PARCELS.

Dequeue:
- Head parcel p = mem[rd_ptr].
- o_is_compressed = (p[1:0] != 2'b11).
- o_instr_valid = (count>=1 && o_is_compressed) || count>=2.
- o_instr = compressed ? {16'h0, p} : {mem[rd_ptr+1], p}. rd_ptr+1 wraps.
- o_instr_pc = head_pc.
- Handshake: o_instr_valid && i_instr_ready && !i_flush. n_deq = compressed ? 1 : 2. rd_ptr += n_deq; head_pc += 2*n_deq.
- A 32-bit instruction whose upper parcel has not yet arrived holds o_instr_valid=0; no NOP is generated.
- There is no enqueue-to-output bypass. Latency is 1 cycle from accept to o_instr_valid.
- o_instr and o_instr_pc hold stable while valid && !ready.

Occupancy:
- count_next = count + n_enq - n_deq. Simultaneous enqueue and dequeue is allowed.
- count never exceeds DEPTH (guaranteed by ready); underflow is impossible by construction.

Flush (highest priority):
- In the flush cycle, any fetch handshake and instruction handshake are ignored.
- Next cycle: count=0, rd_ptr=wr_ptr, head_pc=i_flush_pc, skip_pending=1, skip_n=i_flush_pc[$clog2(FETCH_PARCELS):1].
- The first word accepted after a flush must be the FETCH_PARCELS-aligned word containing i_flush_pc. Supplying that word is the fetch unit's responsibility.
- Back-to-back flushes: the last one wins.

Reset mid-operation clears all state immediately; outputs return to reset values asynchronously.

Assertions (simulation):
- count <= DEPTH.
- head_pc[0] == 0.
- i_fetch_data known when i_fetch_valid.

Test Plan:
1. Reset, FETCH_PARCELS=2, DEPTH=8 -> o_instr_valid=0, o_fetch_ready=1, o_count=0, o_instr_pc=0.
2. Accept 0x00A00513 then 0x45854501 with i_instr_ready=1 -> outputs in order:
   - 0x00A00513 @0x0, comp=0
   - 0x00004501 @0x4, comp=1
   - 0x00004585 @0x6, comp=1
3. Spanning: accept 0x05134501, hold the next word 3 cycles, then accept 0x000000A0 ->
   - 0x4501 @0x0 is output.
   - o_instr_valid=0 with count=1 during the hold.
   - 0x00A00513 @0x2 is output the cycle after the second accept.
4. Flush to 0x102, then accept 0x45854501 -> single output 0x00004585 @0x102, count=1 before dequeue. FETCH_PARCELS=4 variant: flush to 0x106 skips 3 parcels.
5. Full/wrap: i_instr_ready=0, accept 4 compressed words ->
   - count=8, o_fetch_ready=0.
   - Then 12 more words with ready=1 stream in PC order across the pointer wrap, with no loss or duplication.
6. Flush asserted in the same cycle as a fetch accept and an instruction handshake -> fetched data dropped, rd_ptr/head_pc not advanced by the dequeue, next cycle count=0, o_instr_pc=i_flush_pc.
